// File: rtl/e2_bram_pkg.sv
// Shared types and helpers for the e2 simple dual-port block RAM.
package e2_bram_pkg;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_IDLE  = 1'b1
    } state_t;

    function automatic int nbytes(input int width);
        return width / 8;
    endfunction

endpackage

// File: rtl/e2_bram_core.sv
// Raw byte-enable simple dual-port array with a one-cycle registered read.
module e2_bram_core
    import e2_bram_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 64,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                          clk,
    input  logic [nbytes(DATA_WIDTH)-1:0] we,
    input  logic [ADDR_WIDTH-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0]         wdata,
    input  logic                          re,
    input  logic [ADDR_WIDTH-1:0]         raddr,
    output logic [DATA_WIDTH-1:0]         rdata
);

    localparam int NB = nbytes(DATA_WIDTH);

    (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem [DEPTH];

    // NOTE: neither the array nor the read register has a reset; a reset would stop them mapping onto block RAM.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (we[i]) begin
                mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/e2_bram_sdp.sv
// SDP block RAM wrapper: clear sequencer, write mux, write-first collision forwarding,
// optional output register and valid pipeline around e2_bram_core.
module e2_bram_sdp
    import e2_bram_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 64,
    parameter int                    DEPTH        = 64,
    parameter int                    ADDR_WIDTH   = $clog2(DEPTH),
    parameter int                    READ_LATENCY = 1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          init_req,
    output logic                          init_busy,
    input  logic                          en_a,
    input  logic [nbytes(DATA_WIDTH)-1:0] be_a,
    input  logic [ADDR_WIDTH-1:0]         addr_a,
    input  logic [DATA_WIDTH-1:0]         din_a,
    output logic                          wr_drop,
    input  logic                          en_b,
    input  logic [ADDR_WIDTH-1:0]         addr_b,
    output logic [DATA_WIDTH-1:0]         dout_b,
    output logic                          dout_valid_b
);

    localparam int                    NB      = nbytes(DATA_WIDTH);
    localparam logic [ADDR_WIDTH:0]   DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(DEPTH - 1);

    if (DATA_WIDTH % 8 != 0) begin : g_bad_width
        $error("e2_bram_sdp: DATA_WIDTH must be a multiple of 8");
    end
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $error("e2_bram_sdp: READ_LATENCY must be 1 or 2");
    end

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   clr_cnt;
    logic                    a_in, b_in, wr_req, wr_ok, rd_ok;
    logic [NB-1:0]           core_we;
    logic [ADDR_WIDTH-1:0]   core_waddr;
    logic [DATA_WIDTH-1:0]   core_wdata, core_rdata, merged, data1;
    logic                    rd_v1, rd_seen, rd_oob;
    logic [NB-1:0]           fwd_be;
    logic [DATA_WIDTH-1:0]   fwd_din;

    assign a_in   = {1'b0, addr_a} < DEPTH_W;
    assign b_in   = {1'b0, addr_b} < DEPTH_W;
    assign wr_req = en_a && (|be_a);
    assign wr_ok  = wr_req && (state == S_IDLE) && a_in;
    assign rd_ok  = en_b && (state == S_IDLE);

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        core_we    = '0;
        core_waddr = addr_a;
        core_wdata = din_a;
        if (state == S_CLEAR) begin
            core_we    = '1;
            core_waddr = clr_cnt;
            core_wdata = INIT_VALUE;
        end else if (wr_ok) begin
            core_we = be_a;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_CLEAR;
            clr_cnt   <= '0;
            init_busy <= 1'b1;
            wr_drop   <= 1'b0;
        end else begin
            wr_drop <= wr_req && ((state == S_CLEAR) || !a_in);
            case (state)
                S_CLEAR: begin
                    if (clr_cnt == LAST) begin
                        state     <= S_IDLE;
                        init_busy <= 1'b0;
                        clr_cnt   <= '0;
                    end else begin
                        clr_cnt <= clr_cnt + ADDR_WIDTH'(1);
                    end
                end
                S_IDLE: begin
                    if (init_req) begin
                        state     <= S_CLEAR;
                        init_busy <= 1'b1;
                        clr_cnt   <= '0;
                    end
                end
                default: begin
                    state     <= S_CLEAR;
                    init_busy <= 1'b1;
                    clr_cnt   <= '0;
                end
            endcase
        end
    end

    e2_bram_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_core (
        .clk   (clk),
        .we    (core_we),
        .waddr (core_waddr),
        .wdata (core_wdata),
        .re    (rd_ok && b_in),
        .raddr (addr_b),
        .rdata (core_rdata)
    );

    // The array reads old data on a same-address write; the captured bytes patch it afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_v1   <= 1'b0;
            rd_seen <= 1'b0;
            rd_oob  <= 1'b0;
            fwd_be  <= '0;
            fwd_din <= '0;
        end else begin
            rd_v1 <= rd_ok;
            if (rd_ok) begin
                rd_seen <= 1'b1;
                rd_oob  <= !b_in;
                fwd_be  <= (wr_ok && (addr_a == addr_b)) ? be_a : '0;
                fwd_din <= din_a;
            end
        end
    end

    always_comb begin
        merged = core_rdata;
        for (int i = 0; i < NB; i++) begin
            if (fwd_be[i]) begin
                merged[8*i +: 8] = fwd_din[8*i +: 8];
            end
        end
        data1 = merged;
        if (!rd_seen) begin
            data1 = '0;
        end else if (rd_oob) begin
            data1 = INIT_VALUE;
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic [DATA_WIDTH-1:0] dout_q;
        logic                  valid_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                dout_q  <= '0;
                valid_q <= 1'b0;
            end else begin
                valid_q <= rd_v1;
                if (rd_v1) begin
                    dout_q <= data1;
                end
            end
        end
        assign dout_b       = dout_q;
        assign dout_valid_b = valid_q;
    end else begin : g_lat1
        assign dout_b       = data1;
        assign dout_valid_b = rd_v1;
    end

endmodule

// File: tb/tb_e2_bram_sdp.sv
// Self-checking bench for e2_bram_sdp: runs latency-1 and latency-2 instances on shared stimulus.
module tb_e2_bram_sdp;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        init_req = 1'b0;
    logic        en_a = 1'b0;
    logic [7:0]  be_a = '0;
    logic [5:0]  addr_a = '0;
    logic [63:0] din_a = '0;
    logic        en_b = 1'b0;
    logic [5:0]  addr_b = '0;

    logic        busy1, busy2, drop1, drop2, valid1, valid2;
    logic [63:0] dout1, dout2;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b1;

    // Model state: array contents, clear progress and expected outputs after each edge.
    logic [63:0] m_mem [DEPTH];
    bit          m_busy;
    int          m_clr;
    bit          exp_busy, exp_drop, exp_v1, exp_v2, p_acc;
    logic [63:0] exp_d1, exp_d2, p_val;

    always #5 clk = ~clk;

    e2_bram_sdp #(.DATA_WIDTH(64), .DEPTH(DEPTH), .READ_LATENCY(1)) u_lat1 (
        .clk(clk), .rst_n(rst_n), .init_req(init_req), .init_busy(busy1),
        .en_a(en_a), .be_a(be_a), .addr_a(addr_a), .din_a(din_a), .wr_drop(drop1),
        .en_b(en_b), .addr_b(addr_b), .dout_b(dout1), .dout_valid_b(valid1)
    );

    e2_bram_sdp #(.DATA_WIDTH(64), .DEPTH(DEPTH), .READ_LATENCY(2)) u_lat2 (
        .clk(clk), .rst_n(rst_n), .init_req(init_req), .init_busy(busy2),
        .en_a(en_a), .be_a(be_a), .addr_a(addr_a), .din_a(din_a), .wr_drop(drop2),
        .en_b(en_b), .addr_b(addr_b), .dout_b(dout2), .dout_valid_b(valid2)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy   = 1'b1;
        m_clr    = 0;
        exp_busy = 1'b1;
        exp_drop = 1'b0;
        exp_v1   = 1'b0;
        exp_v2   = 1'b0;
        exp_d1   = '0;
        exp_d2   = '0;
        p_acc    = 1'b0;
        p_val    = '0;
    endtask

    // Drive one cycle of inputs (called just after a negedge), predict, and step to the next negedge.
    task automatic cycle(input bit ir, input bit ea, input logic [7:0] be, input logic [5:0] aa,
                         input logic [63:0] da, input bit eb, input logic [5:0] ab);
        bit          acc, wr_ok, drop;
        logic [63:0] val;
        init_req = ir; en_a = ea; be_a = be; addr_a = aa; din_a = da; en_b = eb; addr_b = ab;
        acc   = eb && !m_busy;
        wr_ok = ea && (be != 0) && !m_busy && (int'(aa) < DEPTH);
        drop  = ea && (be != 0) && (m_busy || int'(aa) >= DEPTH);
        val   = '0;
        if (acc && int'(ab) < DEPTH) begin
            val = m_mem[ab];
            for (int i = 0; i < 8; i++)
                if (wr_ok && aa == ab && be[i]) val[8*i +: 8] = da[8*i +: 8];
        end
        if (wr_ok)
            for (int i = 0; i < 8; i++)
                if (be[i]) m_mem[aa][8*i +: 8] = da[8*i +: 8];
        if (m_busy) begin
            m_mem[m_clr] = '0;
            m_clr++;
            if (m_clr == DEPTH) m_busy = 1'b0;
        end else if (ir) begin
            m_busy = 1'b1;
            m_clr  = 0;
        end
        @(posedge clk);
        exp_busy = m_busy;
        exp_drop = drop;
        exp_v2   = p_acc;
        if (p_acc) exp_d2 = p_val;
        exp_v1   = acc;
        if (acc) exp_d1 = val;
        p_acc = acc;
        p_val = val;
        @(negedge clk);
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 8'h00, 6'd0, 64'd0, 1'b0, 6'd0);
    endtask

    task automatic do_reset(input int n);
        #1;
        rst_n = 1'b0;
        init_req = 1'b0; en_a = 1'b0; en_b = 1'b0; be_a = '0;
        model_reset();
        repeat (n) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Counts busy cycles starting at the current negedge; bounded so a stuck busy still terminates.
    task automatic count_busy(output int n);
        n = 0;
        while (busy1 && n < 200) begin
            n++;
            idle();
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("busy_lat1", busy1, exp_busy);
            check("busy_lat2", busy2, exp_busy);
            check("drop_lat1", drop1, exp_drop);
            check("drop_lat2", drop2, exp_drop);
            check("valid_lat1", valid1, exp_v1);
            check("valid_lat2", valid2, exp_v2);
            check("dout_lat1", dout1, exp_d1);
            check("dout_lat2", dout2, exp_d2);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int vcnt;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_busy", busy1, 64'd1);
        check("reset_dout", dout1, 64'd0);
        check("reset_dout2", dout2, 64'd0);
        check("reset_valid", valid1, 64'd0);
        check("reset_drop", drop1, 64'd0);
        rst_n = 1'b1;

        count_busy(n);
        check("busy_len_after_reset", n, 64'd64);
        for (int a = 0; a < DEPTH; a++) cycle(1'b0, 1'b0, 8'h00, 6'd0, 64'd0, 1'b1, 6'(a));
        idle(); idle();

        cycle(1'b0, 1'b1, 8'hFF, 6'd5, 64'h0123456789ABCDEF, 1'b0, 6'd0);
        cycle(1'b0, 1'b1, 8'h0F, 6'd5, 64'hFFFFFFFFFFFFFFFF, 1'b0, 6'd0);
        cycle(1'b0, 1'b0, 8'h00, 6'd0, 64'd0, 1'b1, 6'd5);
        check("addr5_lat1_valid", valid1, 64'd1);
        check("addr5_lat1_data", dout1, 64'h01234567FFFFFFFF);
        check("addr5_lat2_early", valid2, 64'd0);
        idle();
        check("addr5_lat1_drop_valid", valid1, 64'd0);
        check("addr5_lat2_valid", valid2, 64'd1);
        check("addr5_lat2_data", dout2, 64'h01234567FFFFFFFF);

        cycle(1'b0, 1'b1, 8'hF0, 6'd9, 64'hAAAAAAAAAAAAAAAA, 1'b1, 6'd9);
        check("collide_lat1", dout1, 64'hAAAAAAAA00000000);
        idle();
        check("collide_lat2", dout2, 64'hAAAAAAAA00000000);

        for (int a = 0; a < DEPTH; a++)
            cycle(1'b0, 1'b1, 8'hFF, 6'(a), {$urandom, $urandom}, 1'b0, 6'd0);
        vcnt = 0;
        for (int a = 0; a < DEPTH; a++) begin
            cycle(1'b0, 1'b1, 8'($urandom), 6'($urandom_range(0, 63)), {$urandom, $urandom},
                  1'b1, 6'(a));
            if (valid1) vcnt++;
        end
        check("b2b_valid_count", vcnt, 64'd64);
        cycle(1'b0, 1'b1, 8'h3C, 6'd17, 64'h1122334455667788, 1'b1, 6'd17);
        idle(); idle();

        cycle(1'b1, 1'b0, 8'h00, 6'd0, 64'd0, 1'b0, 6'd0);
        cycle(1'b0, 1'b1, 8'hFF, 6'd3, 64'hDEADBEEFDEADBEEF, 1'b1, 6'd3);
        check("clear_wr_drop", drop1, 64'd1);
        check("clear_read_novalid", valid1, 64'd0);
        cycle(1'b0, 1'b1, 8'h00, 6'd4, 64'hDEADBEEFDEADBEEF, 1'b0, 6'd0);
        check("clear_be0_nodrop", drop1, 64'd0);
        count_busy(n);
        check("clear_busy_bounded", n < 200, 64'd1);
        for (int a = 0; a < DEPTH; a++) cycle(1'b0, 1'b0, 8'h00, 6'd0, 64'd0, 1'b1, 6'(a));
        idle(); idle();

        do_reset(2);
        repeat (30) idle();
        do_reset(3);
        count_busy(n);
        check("busy_len_after_midclear_reset", n, 64'd64);
        cycle(1'b0, 1'b0, 8'h00, 6'd0, 64'd0, 1'b1, 6'd5);
        idle(); idle();

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
